// File: rtl/ssd_scan_ctrl.sv
// Multiplexed N-digit seven-segment scanner with a cursor-addressed hex value bank,
// refresh prescaler, inter-digit blanking and per-digit blank/decimal-point masks.
module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16,
    localparam int CW         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_data,
    input  logic              next_in,
    input  logic              clr,
    input  logic [DIGITS-1:0] blank_mask,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [CW-1:0]     cursor,
    output logic [DIGITS-1:0] AN,
    output logic [7:0]        seg_out
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLANK_LD  = BW'(BLANK_CYC);
    localparam logic [CW-1:0] IDX_LAST  = CW'(DIGITS - 1);

    logic [PW-1:0]     pre_cnt;
    logic [BW-1:0]     blank_cnt;
    logic [CW-1:0]     scan_idx;
    logic              tick;
    logic              sync_1;
    logic              sync_2;
    logic              sync_prev;
    logic              nxt;
    logic [3:0]        digit_val [DIGITS];
    logic [DIGITS-1:0] an_next;
    logic [7:0]        seg_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick = (pre_cnt == PRE_LAST);
    assign nxt  = sync_2 & ~sync_prev;

    // Refresh timing; deliberately ignores clr so the scan never loses phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt   <= '0;
            scan_idx  <= '0;
            blank_cnt <= '0;
        end else begin
            if (tick) begin
                pre_cnt   <= '0;
                scan_idx  <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
                blank_cnt <= BLANK_LD;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                if (blank_cnt != '0) begin
                    blank_cnt <= blank_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= next_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    // A write in the same cycle as an advance lands on the old cursor.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_val[i] <= '0;
            end
            cursor <= '0;
        end else if (clr) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit_val[i] <= '0;
            end
            cursor <= '0;
        end else begin
            if (wr_en) begin
                digit_val[cursor] <= wr_data;
            end
            if (nxt) begin
                cursor <= (cursor == IDX_LAST) ? '0 : cursor + 1'b1;
            end
        end
    end

    always_comb begin
        an_next  = '1;
        seg_next = 8'hFF;
        if ((blank_cnt == '0) && !blank_mask[scan_idx]) begin
            an_next       = ~({{(DIGITS-1){1'b0}}, 1'b1} << scan_idx);
            seg_next[6:0] = hex_to_seg(digit_val[scan_idx]);
            seg_next[7]   = ~dp_mask[scan_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            AN      <= '1;
            seg_out <= 8'hFF;
        end else begin
            AN      <= an_next;
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.
module tb_ssd_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       next_in = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] blank_mask = 4'h0;
    logic [3:0] dp_mask = 4'h0;
    logic [1:0] cursor;
    logic [3:0] AN;
    logic [7:0] seg_out;

    int tests_run = 0;
    int tests_failed = 0;

    // Hand-derived AN sequence for the first 17 cycles after reset release:
    // slot 0 is lit for 4 cycles, then every slot is 1 dark + 3 lit.
    logic [3:0] an_tab [17] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .next_in    (next_in),
        .clr        (clr),
        .blank_mask (blank_mask),
        .dp_mask    (dp_mask),
        .cursor     (cursor),
        .AN         (AN),
        .seg_out    (seg_out)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [3:0] data, input logic nx, input logic cl);
        wr_en   = we;
        wr_data = data;
        next_in = nx;
        clr     = cl;
        step(1);
        wr_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic pulseNext();
        next_in = 1'b1;
        step(3);
        next_in = 1'b0;
        step(3);
    endtask

    // Returns on the first lit cycle of digit d's slot (after a dark cycle).
    task automatic waitSlot(input int d, input string tag);
        logic [3:0] target;
        bit ok;
        target = ~(4'b0001 << d);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1);
            if (AN === 4'hF) ok = 1'b1;
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 40 && !ok; i++) begin
                step(1);
                if (AN === target) ok = 1'b1;
            end
        end
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL %s: timeout waiting for AN %h, got %h", tag, target, AN);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // 1: reset state, then scan order and slot timing
        step(3);
        checkOutput("rst_an", {4'h0, AN}, 8'h0F);
        checkOutput("rst_seg", seg_out, 8'hFF);
        checkOutput("rst_cursor", {6'h0, cursor}, 8'h00);
        reset = 1'b1;
        for (int k = 0; k < 17; k++) begin
            step(1);
            checkOutput($sformatf("scan_an_%0d", k + 1), {4'h0, AN}, {4'h0, an_tab[k]});
            checkOutput($sformatf("scan_seg_%0d", k + 1), seg_out,
                        (an_tab[k] == 4'hF) ? 8'hFF : 8'hC0);
        end

        // 2: writes through the cursor
        applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
        pulseNext();
        checkOutput("cursor_after_1", {6'h0, cursor}, 8'h01);
        applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
        pulseNext();
        applyStimulus(1'b1, 4'h8, 1'b0, 1'b0);
        checkOutput("cursor_after_2", {6'h0, cursor}, 8'h02);
        waitSlot(0, "wait_d0");
        checkOutput("digit0_3", seg_out, 8'hB0);
        waitSlot(1, "wait_d1");
        checkOutput("digit1_A", seg_out, 8'h88);
        waitSlot(2, "wait_d2");
        checkOutput("digit2_8", seg_out, 8'h80);

        // 3: held button, wrap, simultaneous write and advance
        next_in = 1'b1;
        step(10);
        checkOutput("hold_one_adv", {6'h0, cursor}, 8'h03);
        next_in = 1'b0;
        step(3);
        checkOutput("hold_release", {6'h0, cursor}, 8'h03);
        for (int p = 0; p < 4; p++) pulseNext();
        checkOutput("wrap_four", {6'h0, cursor}, 8'h03);
        pulseNext();
        pulseNext();
        checkOutput("to_one", {6'h0, cursor}, 8'h01);
        next_in = 1'b1;
        step(2);
        applyStimulus(1'b1, 4'h5, 1'b1, 1'b0);
        checkOutput("wr_nxt_cursor", {6'h0, cursor}, 8'h02);
        next_in = 1'b0;
        step(3);
        waitSlot(1, "wait_d1_wr");
        checkOutput("wr_nxt_digit1", seg_out, 8'h92);
        waitSlot(2, "wait_d2_keep");
        checkOutput("digit2_kept", seg_out, 8'h80);

        // 4: blank and decimal-point masks
        blank_mask = 4'b0100;
        dp_mask    = 4'b0001;
        for (int c = 0; c < 32; c++) begin
            step(1);
            tests_run++;
            assert (AN !== 4'b1011) else begin
                tests_failed++;
                $error("[TB] FAIL blank_d2_%0d: got AN %h, must not be b", c, AN);
            end
        end
        waitSlot(0, "wait_dp0");
        checkOutput("dp_digit0", seg_out, 8'h30);
        waitSlot(1, "wait_dp1");
        checkOutput("dp_digit1", seg_out, 8'h92);
        waitSlot(3, "wait_dp3");
        checkOutput("dp_digit3", seg_out, 8'hC0);
        blank_mask = 4'h0;
        dp_mask    = 4'h0;

        // 5: clr beats wr_en; scan phase continues
        waitSlot(0, "wait_clr");
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1);
        checkOutput("clr_an_1", {4'h0, AN}, 8'h0E);
        checkOutput("clr_cursor", {6'h0, cursor}, 8'h00);
        step(1);
        checkOutput("clr_an_2", {4'h0, AN}, 8'h0E);
        checkOutput("clr_digit0", seg_out, 8'hC0);
        step(1);
        checkOutput("clr_dark", {4'h0, AN}, 8'h0F);
        step(1);
        checkOutput("clr_an_d1", {4'h0, AN}, 8'h0D);
        checkOutput("clr_digit1", seg_out, 8'hC0);
        waitSlot(2, "wait_clr_d2");
        checkOutput("clr_digit2", seg_out, 8'hC0);

        // 6: async reset mid-slot
        applyStimulus(1'b1, 4'h7, 1'b0, 1'b0);
        waitSlot(0, "wait_pre_rst");
        checkOutput("pre_rst_digit0", seg_out, 8'hF8);
        step(1);
        checkOutput("pre_rst_lit", {4'h0, AN}, 8'h0E);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_an", {4'h0, AN}, 8'h0F);
        checkOutput("async_seg", seg_out, 8'hFF);
        step(1);
        checkOutput("held_an", {4'h0, AN}, 8'h0F);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            checkOutput($sformatf("restart_an_%0d", k + 1), {4'h0, AN}, {4'h0, an_tab[k]});
        end
        checkOutput("restart_d1_zero", seg_out, 8'hC0);
        waitSlot(0, "wait_post_rst");
        checkOutput("post_rst_digit0", seg_out, 8'hC0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
